// File: rtl/alu_arbiter.sv
// Two-port round-robin front end for a shared combinational ALU.
// Holds one operation at a time: accept, execute for 1 or MULDIV_CYCLES cycles, return a tagged response.
module alu_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ALU_CONTROL_WIDTH = 4,
  parameter int MULDIV_CYCLES = 3,
  parameter logic [ALU_CONTROL_WIDTH-1:0] MUL_CODE = 4'b0001,
  parameter logic [ALU_CONTROL_WIDTH-1:0] DIV_CODE = 4'b0010
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req0_valid,
  output logic                         req0_ready,
  input  logic [DATA_WIDTH-1:0]        req0_a,
  input  logic [DATA_WIDTH-1:0]        req0_b,
  input  logic [ALU_CONTROL_WIDTH-1:0] req0_ctrl,
  input  logic                         req1_valid,
  output logic                         req1_ready,
  input  logic [DATA_WIDTH-1:0]        req1_a,
  input  logic [DATA_WIDTH-1:0]        req1_b,
  input  logic [ALU_CONTROL_WIDTH-1:0] req1_ctrl,
  output logic [DATA_WIDTH-1:0]        alu_a,
  output logic [DATA_WIDTH-1:0]        alu_b,
  output logic [ALU_CONTROL_WIDTH-1:0] alu_ctrl,
  input  logic [DATA_WIDTH-1:0]        alu_r,
  input  logic [DATA_WIDTH-1:0]        alu_s,
  input  logic                         alu_exc,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic                         resp_id,
  output logic [DATA_WIDTH-1:0]        resp_r,
  output logic [DATA_WIDTH-1:0]        resp_s,
  output logic                         resp_exc,
  output logic                         busy
);

  localparam int CNT_W = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                       state_reg, state_next;
  logic                         last_grant_reg;
  logic [DATA_WIDTH-1:0]        a_reg, b_reg;
  logic [ALU_CONTROL_WIDTH-1:0] ctrl_reg;
  logic                         id_reg;
  logic [CNT_W-1:0]             cnt_reg;
  logic [DATA_WIDTH-1:0]        resp_r_reg, resp_s_reg;
  logic                         resp_exc_reg;

  logic                         grant;
  logic                         handshake;
  logic [ALU_CONTROL_WIDTH-1:0] sel_ctrl;
  logic                         sel_muldiv;
  logic                         div_zero;
  logic                         nop;

  // Tie-break favours whichever requester did not finish last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant_reg;
    else if (req1_valid)          grant = 1'b1;
  end

  assign handshake  = (state_reg == IDLE) && !rst && (req0_valid || req1_valid);
  assign sel_ctrl   = grant ? req1_ctrl : req0_ctrl;
  assign sel_muldiv = (sel_ctrl == MUL_CODE) || (sel_ctrl == DIV_CODE);
  assign div_zero   = (ctrl_reg == DIV_CODE) && (b_reg == '0);
  assign nop        = (ctrl_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (handshake) state_next = EXEC;
      EXEC:    if (cnt_reg == '0) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    alu_ctrl   = '0;
    case (state_reg)
      IDLE: begin
        busy       = 1'b0;
        req0_ready = handshake && !grant;
        req1_ready = handshake && grant;
      end
      EXEC:    if (!div_zero) alu_ctrl = ctrl_reg;
      RESP:    resp_valid = 1'b1;
      default: busy = 1'b1;
    endcase
  end

  // Operand registers change only on acceptance, so the ALU sees the last operands when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
      a_reg          <= '0;
      b_reg          <= '0;
      ctrl_reg       <= '0;
      id_reg         <= 1'b0;
      cnt_reg        <= '0;
      resp_r_reg     <= '0;
      resp_s_reg     <= '0;
      resp_exc_reg   <= 1'b0;
    end else begin
      if (handshake) begin
        a_reg    <= grant ? req1_a : req0_a;
        b_reg    <= grant ? req1_b : req0_b;
        ctrl_reg <= sel_ctrl;
        id_reg   <= grant;
        cnt_reg  <= sel_muldiv ? CNT_W'(MULDIV_CYCLES - 1) : '0;
      end else if (state_reg == EXEC && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - 1'b1;
      end

      if (state_reg == EXEC && cnt_reg == '0) begin
        if (div_zero || nop) begin
          resp_r_reg   <= '0;
          resp_s_reg   <= '0;
          resp_exc_reg <= div_zero;
        end else begin
          resp_r_reg   <= alu_r;
          resp_s_reg   <= alu_s;
          resp_exc_reg <= alu_exc;
        end
      end

      if (state_reg == RESP && resp_ready) last_grant_reg <= id_reg;
    end
  end

  assign alu_a    = a_reg;
  assign alu_b    = b_reg;
  assign resp_id  = id_reg;
  assign resp_r   = resp_r_reg;
  assign resp_s   = resp_s_reg;
  assign resp_exc = resp_exc_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: a transaction-level reference (busy flag, remaining-exec countdown, expected
// result from plain arithmetic) checked every cycle, plus directed vectors with literal expectations.
module tb_alu_arbiter;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int MDC = 3;
  localparam logic [CW-1:0] ADD = 4'b1111;
  localparam logic [CW-1:0] MUL = 4'b0001;
  localparam logic [CW-1:0] DIV = 4'b0010;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [DW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [CW-1:0] req0_ctrl = '0, req1_ctrl = '0;
  logic [DW-1:0] alu_a, alu_b, alu_r, alu_s;
  logic [CW-1:0] alu_ctrl;
  logic alu_exc;
  logic resp_valid, resp_ready = 1'b1, resp_id, resp_exc, busy;
  logic [DW-1:0] resp_r, resp_s;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl), .alu_r(alu_r), .alu_s(alu_s), .alu_exc(alu_exc),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_r(resp_r), .resp_s(resp_s), .resp_exc(resp_exc), .busy(busy)
  );

  always #5 clk = ~clk;

  // Environment ALU: {r, s, exc}.
  function automatic logic [2*DW:0] alu_fn(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    logic [2*DW-1:0] p;
    logic [DW-1:0] sum;
    case (c)
      4'h0: return '0;
      ADD: begin
        sum = a + b;
        return {sum, {DW{1'b0}}, (a[DW-1] == b[DW-1]) && (sum[DW-1] != a[DW-1])};
      end
      MUL: begin
        p = a * b;
        return {p[DW-1:0], p[2*DW-1:DW], 1'b0};
      end
      DIV: begin
        if (b == 0) return {{(2*DW){1'b0}}, 1'b1};
        return {a / b, a % b, 1'b0};
      end
      default: return {a ^ b, {DW{1'b0}}, 1'b1};
    endcase
  endfunction

  always_comb {alu_r, alu_s, alu_exc} = alu_fn(alu_a, alu_b, alu_ctrl);

  // What the requester should get back, independent of what the ALU is shown.
  function automatic logic [2*DW:0] golden(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [CW-1:0] c);
    if (c == DIV && b == 0) return {{(2*DW){1'b0}}, 1'b1};
    return alu_fn(a, b, c);
  endfunction

  function automatic logic grant_of(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return !last;
    return v1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding op, m_left = exec cycles still to run.
  logic m_busy = 1'b0, m_last = 1'b1, m_id = 1'b0;
  int m_left = 0;
  logic [DW-1:0] m_a, m_b;
  logic [CW-1:0] m_ctrl;
  logic [2*DW:0] m_exp;
  logic g_m;
  logic [DW-1:0] g_a, g_b;
  logic [CW-1:0] g_ctrl;

  always_comb begin
    g_m    = grant_of(req0_valid, req1_valid, m_last);
    g_a    = g_m ? req1_a : req0_a;
    g_b    = g_m ? req1_b : req0_b;
    g_ctrl = g_m ? req1_ctrl : req0_ctrl;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_last <= 1'b1;
      m_left <= 0;
    end else if (!m_busy) begin
      if (req0_valid || req1_valid) begin
        m_busy <= 1'b1;
        m_id   <= g_m;
        m_a    <= g_a;
        m_b    <= g_b;
        m_ctrl <= g_ctrl;
        m_left <= (g_ctrl == MUL || g_ctrl == DIV) ? MDC : 1;
        m_exp  <= golden(g_a, g_b, g_ctrl);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (resp_ready) begin
      m_busy <= 1'b0;
      m_last <= m_id;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic idle_ok;
      logic exec;
      idle_ok = !rst && !m_busy && (req0_valid || req1_valid);
      exec = m_busy && m_left > 0;
      chk("m_ready0", req0_ready, idle_ok && !g_m);
      chk("m_ready1", req1_ready, idle_ok && g_m);
      chk("m_busy", busy, m_busy);
      chk("m_resp_valid", resp_valid, m_busy && m_left == 0);
      chk("m_alu_ctrl", alu_ctrl, (exec && !(m_ctrl == DIV && m_b == 0)) ? m_ctrl : 4'h0);
      if (exec) begin
        chk("m_alu_a", alu_a, m_a);
        chk("m_alu_b", alu_b, m_b);
      end
      if (m_busy && m_left == 0) begin
        chk("m_resp_id", resp_id, m_id);
        chk("m_resp", {resp_r, resp_s, resp_exc}, m_exp);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
  endtask

  int n, lat;
  logic seen;
  logic [DW-1:0] rr, rs;
  logic rid, rexc;
  int grants[$];

  // Runs 6 cycles after a handshake; counts cycles alu_ctrl==code and records the response.
  task automatic watch(input logic [CW-1:0] code);
    n = 0; seen = 1'b0; lat = -1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (alu_ctrl == code && code != 0) n++;
      if (code == 0 && alu_ctrl != 0) n++;
      if (resp_valid && !seen) begin
        seen = 1'b1; lat = i; rr = resp_r; rs = resp_s; rid = resp_id; rexc = resp_exc;
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_r", resp_r, 0);
    chk("rst_alu", {alu_a, alu_b, alu_ctrl}, 0);
    chk("rst_ready0", req0_ready, 0);
    tick(); rst = 1'b0; chk_en = 1'b1;

    // ADD 3+4 from req0
    req0_a = 16'h0003; req0_b = 16'h0004; req0_ctrl = ADD; req0_valid = 1'b1;
    @(negedge clk); chk("t1_ready0", req0_ready, 1);
    tick(); req0_valid = 1'b0;
    @(negedge clk); chk("t1_alu_ctrl", alu_ctrl, ADD);
    tick();
    @(negedge clk);
    chk("t1_resp", {resp_valid, resp_id, resp_r, resp_s, resp_exc}, {1'b1, 1'b0, 16'h0007, 16'h0000, 1'b0});

    // Both requesting continuously: alternation starting at 0
    do_reset();
    req0_a = 16'h0001; req0_b = 16'h0001; req0_ctrl = ADD;
    req1_a = 16'h0002; req1_b = 16'h0002; req1_ctrl = ADD;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (req0_ready) grants.push_back(0);
      if (req1_ready) grants.push_back(1);
    end
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    chk("t2_grant_count", grants.size(), 4);
    if (grants.size() == 4) begin
      for (int i = 0; i < 4; i++) chk($sformatf("t2_grant%0d", i), grants[i], i % 2);
    end

    // MUL on req1
    req1_a = 16'h0100; req1_b = 16'h0100; req1_ctrl = MUL; req1_valid = 1'b1;
    @(negedge clk); chk("t3_ready1", req1_ready, 1);
    tick(); req1_valid = 1'b0;
    watch(MUL);
    chk("t3_mul_cycles", n, 3);
    chk("t3_seen", seen, 1);
    chk("t3_latency", lat, 3);
    chk("t3_resp", {rid, rr, rs, rexc}, {1'b1, 16'h0000, 16'h0001, 1'b0});

    // DIV by zero on req0
    tick();
    req0_a = 16'h0009; req0_b = 16'h0000; req0_ctrl = DIV; req0_valid = 1'b1;
    @(negedge clk); chk("t4_ready0", req0_ready, 1);
    tick(); req0_valid = 1'b0;
    watch(4'h0);
    chk("t4_alu_ctrl_nonzero", n, 0);
    chk("t4_seen", seen, 1);
    chk("t4_latency", lat, 3);
    chk("t4_resp", {rid, rr, rs, rexc}, {1'b0, 16'h0000, 16'h0000, 1'b1});

    // Overflowing ADD with back-pressure; req1 waits
    tick();
    resp_ready = 1'b0;
    req0_a = 16'h7FFF; req0_b = 16'h0001; req0_ctrl = ADD; req0_valid = 1'b1;
    @(negedge clk); chk("t5_ready0", req0_ready, 1);
    tick(); req0_valid = 1'b0;
    req1_a = 16'h0005; req1_b = 16'h0005; req1_ctrl = ADD; req1_valid = 1'b1;
    @(negedge clk); chk("t5_exec_ready1", req1_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("t5_hold", {resp_valid, resp_r, resp_exc, req1_ready}, {1'b1, 16'h8000, 1'b1, 1'b0});
    end
    tick(); resp_ready = 1'b1;
    tick();
    @(negedge clk);
    chk("t5_idle_busy", busy, 0);
    chk("t5_ready1_after", req1_ready, 1);
    tick(); req1_valid = 1'b0;
    repeat (3) tick();

    // NOP on req0 (so last grant is 0), then reset during a req1 MUL
    req0_a = 16'h0005; req0_b = 16'h0006; req0_ctrl = 4'h0; req0_valid = 1'b1;
    tick(); req0_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_nop_resp", {resp_valid, resp_r, resp_s, resp_exc}, {1'b1, 16'h0000, 16'h0000, 1'b0});
    tick();
    req1_a = 16'h0003; req1_b = 16'h0003; req1_ctrl = MUL; req1_valid = 1'b1;
    @(negedge clk); chk("t6_ready1", req1_ready, 1);
    tick(); req1_valid = 1'b0;
    @(negedge clk); chk("t6_exec_ctrl", alu_ctrl, MUL);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    req0_a = 16'h0001; req0_b = 16'h0002; req0_ctrl = ADD; req0_valid = 1'b1;
    req1_a = 16'h0004; req1_b = 16'h0004; req1_ctrl = ADD; req1_valid = 1'b1;
    @(negedge clk);
    chk("t6_post_rst", {busy, alu_ctrl, resp_valid}, 0);
    chk("t6_grant", {req0_ready, req1_ready}, 2'b10);
    tick(); req0_valid = 1'b0; req1_valid = 1'b0;
    watch(ADD);
    chk("t6_resp", {rid, rr, rexc}, {1'b0, 16'h0003, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
